// File: rtl/sint_window_max_pkg.sv
// Shared types and sizing helpers for the signed window-maximum reducer.
package sint_window_max_pkg;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_WINDOW = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Index width is at least one bit so a single-sample window still has a port.
  function automatic int idx_width(input int window);
    return (window > 2) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/sint_max_update.sv
// Running-maximum update: signed strict greater-than, so ties keep the earliest index.
module sint_max_update
  import sint_window_max_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = 1
) (
  input  logic [WIDTH-1:0] sample_i,
  input  logic [WIDTH-1:0] run_max_i,
  input  logic [IDXW-1:0]  run_idx_i,
  input  logic [IDXW-1:0]  count_i,
  input  logic             first_i,
  output logic [WIDTH-1:0] max_nxt_o,
  output logic [IDXW-1:0]  idx_nxt_o
);

  always_comb begin
    max_nxt_o = run_max_i;
    idx_nxt_o = run_idx_i;
    if (first_i) begin
      max_nxt_o = sample_i;
      idx_nxt_o = '0;
    end else if ($signed(sample_i) > $signed(run_max_i)) begin
      max_nxt_o = sample_i;
      idx_nxt_o = count_i;
    end
  end

endmodule

// File: rtl/sint_window_max.sv
// Streaming reducer: emits the signed maximum and its index for every WINDOW accepted samples.
//   state | meaning
//   ACCUM | collecting samples of the current window, no result held
//   HOLD  | result presented on O/O_idx, waiting for O_ready
module sint_window_max
  import sint_window_max_pkg::*;
#(
  parameter int  WIDTH  = DEF_WIDTH,
  parameter int  WINDOW = DEF_WINDOW,
  localparam int IDXW   = idx_width(WINDOW)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic [IDXW-1:0]  O_idx,
  output logic             O_valid,
  input  logic             O_ready
);

  localparam logic [IDXW-1:0] LAST = IDXW'(WINDOW - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [IDXW-1:0]  run_idx_q, run_idx_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [IDXW-1:0]  o_idx_q, o_idx_d;

  logic             accept;
  logic             first;
  logic [WIDTH-1:0] max_nxt;
  logic [IDXW-1:0]  idx_nxt;

  // In HOLD a new sample can only enter in the same cycle the result is popped.
  assign I_ready = (state_q == ACCUM) || O_ready;
  assign accept  = I_valid && I_ready;
  assign first   = (state_q == HOLD) || (count_q == '0);

  sint_max_update #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_update (
    .sample_i  (I),
    .run_max_i (run_max_q),
    .run_idx_i (run_idx_q),
    .count_i   (count_q),
    .first_i   (first),
    .max_nxt_o (max_nxt),
    .idx_nxt_o (idx_nxt)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    o_d       = o_q;
    o_idx_d   = o_idx_q;

    if ((state_q == HOLD) && O_ready) begin
      state_d = ACCUM;
    end

    if (accept) begin
      run_max_d = max_nxt;
      run_idx_d = idx_nxt;
      if (count_q == LAST) begin
        o_d     = max_nxt;
        o_idx_d = idx_nxt;
        count_d = '0;
        state_d = HOLD;
      end else begin
        count_d = count_q + IDXW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ACCUM;
      count_q   <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      o_q       <= '0;
      o_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      o_q       <= o_d;
      o_idx_q   <= o_idx_d;
    end
  end

  assign O       = o_q;
  assign O_idx   = o_idx_q;
  assign O_valid = (state_q == HOLD);

endmodule

// File: tb/tb_sint_window_max.sv
// Directed bench for sint_window_max at WIDTH=3, WINDOW=4 with hand-computed results.
module tb_sint_window_max;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] I;
  logic       I_valid;
  logic       I_ready;
  logic [2:0] O;
  logic [1:0] O_idx;
  logic       O_valid;
  logic       O_ready;

  int n_checks = 0;
  int n_errors = 0;
  int pops     = 0;

  sint_window_max #(
    .WIDTH  (3),
    .WINDOW (4)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .I       (I),
    .I_valid (I_valid),
    .I_ready (I_ready),
    .O       (O),
    .O_idx   (O_idx),
    .O_valid (O_valid),
    .O_ready (O_ready)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!RESET && O_valid && O_ready) pops++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, then settle just after the edge.
  task automatic cyc(input int v, input logic vld);
    I       = v[2:0];
    I_valid = vld;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int seq [8];

    RESET   = 1'b1;
    I       = '0;
    I_valid = 1'b0;
    O_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_o_valid", O_valid, 0);
    check("rst_o",       O,       0);
    check("rst_o_idx",   O_idx,   0);
    check("rst_i_ready", I_ready, 1);
    RESET = 1'b0;

    // window 1,-2,3,0
    cyc(1, 1); cyc(-2, 1); cyc(3, 1);
    check("t1_not_early", O_valid, 0);
    cyc(0, 1);
    I_valid = 1'b0;
    check("t1_valid", O_valid, 1);
    check("t1_o",     O,       3);
    check("t1_idx",   O_idx,   2);
    cyc(0, 0);
    check("t1_one_cycle", O_valid, 0);

    // most negative everywhere: first sample wins unconditionally
    cyc(-4, 1); cyc(-4, 1); cyc(-4, 1); cyc(-4, 1);
    I_valid = 1'b0;
    check("t2_valid", O_valid, 1);
    check("t2_o",     O,       3'b100);
    check("t2_idx",   O_idx,   0);
    cyc(0, 0);

    // tie keeps earliest index
    cyc(-1, 1); cyc(2, 1); cyc(2, 1); cyc(-3, 1);
    I_valid = 1'b0;
    check("t3_o",   O,     2);
    check("t3_idx", O_idx, 1);
    cyc(0, 0);

    // backpressure
    cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(3, 1);
    O_ready = 1'b0;
    I       = 3'd2;
    I_valid = 1'b1;
    #1;
    check("t4_i_ready_comb", I_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      check("t4_i_ready", I_ready, 0);
      check("t4_valid",   O_valid, 1);
      check("t4_o",       O,       3);
      check("t4_idx",     O_idx,   3);
    end
    O_ready = 1'b1;
    #1;
    check("t4_i_ready_release", I_ready, 1);
    @(posedge CLK);
    #1;
    check("t4_popped", O_valid, 0);
    cyc(0, 1); cyc(1, 1); cyc(0, 1);
    I_valid = 1'b0;
    check("t4_next_valid", O_valid, 1);
    check("t4_next_o",     O,       2);
    check("t4_next_idx",   O_idx,   0);
    cyc(0, 0);

    // reset mid-window discards the partial window
    cyc(3, 1); cyc(3, 1);
    I_valid = 1'b0;
    RESET   = 1'b1;
    cyc(0, 0);
    RESET = 1'b0;
    check("t5_rst_valid", O_valid, 0);
    check("t5_rst_o",     O,       0);
    cyc(-1, 1); cyc(-3, 1); cyc(-2, 1);
    check("t5_not_early", O_valid, 0);
    cyc(-4, 1);
    I_valid = 1'b0;
    check("t5_valid", O_valid, 1);
    check("t5_o",     O,       3'b111);
    check("t5_idx",   O_idx,   0);
    cyc(0, 0);

    // back-to-back windows with I_valid held high
    seq = '{0, 1, 2, 3, 3, 2, 1, 0};
    for (int k = 0; k < 8; k++) begin
      I       = seq[k][2:0];
      I_valid = 1'b1;
      #1;
      check("t6_i_ready", I_ready, 1);
      @(posedge CLK);
      #1;
      if (k == 3) begin
        check("t6_w0_valid", O_valid, 1);
        check("t6_w0_o",     O,       3);
        check("t6_w0_idx",   O_idx,   3);
      end
      if (k == 4) check("t6_w0_popped", O_valid, 0);
    end
    I_valid = 1'b0;
    check("t6_w1_valid", O_valid, 1);
    check("t6_w1_o",     O,       3);
    check("t6_w1_idx",   O_idx,   0);
    cyc(0, 0);
    check("t6_w1_popped", O_valid, 0);

    check("total_pops", pops, 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
